sram_req_ctrl: RTL

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_req_ctrl_pkg.sv | 24 ++
 rtl/sram_rsp_fifo.sv | 55 +++++
 rtl/sram_req_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared widths, controller state type and byte-enable expansion for sram_req_ctrl.
// Optional response queue is selected with the SRAM_REQ_CTRL_RSPQ_EN macro.
package sram_req_ctrl_pkg;

    localparam int SRAM_AW  = 10;
    localparam int SRAM_DW  = 32;
    localparam int SRAM_BEW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_CAP,
        ST_RSP
    } state_t;

    function automatic logic [SRAM_DW-1:0] be_to_bm(input logic [SRAM_BEW-1:0] be);
        logic [SRAM_DW-1:0] bm;
        for (int i = 0; i < SRAM_BEW; i++) begin
            bm[8*i +: 8] = {8{be[i]}};
        end
        return bm;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO for sram_req_ctrl; built only when
// SRAM_REQ_CTRL_RSPQ_EN is defined.
`ifdef SRAM_REQ_CTRL_RSPQ_EN
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage is deliberately left unreset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule
`endif

// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port SRAM macro with registered pins.
// Define SRAM_REQ_CTRL_RSPQ_EN for pipelined reads through a response FIFO.
module sram_req_ctrl
    import sram_req_ctrl_pkg::*;
#(
    parameter int RSPQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [SRAM_AW-1:0]  req_addr,
    input  logic [SRAM_BEW-1:0] req_be,
    input  logic [SRAM_DW-1:0]  req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SRAM_DW-1:0]  rsp_rdata,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_bm,
    output logic [SRAM_DW-1:0]  sram_din,
    output logic                sram_men,
    output logic                sram_wen,
    output logic                sram_ren,
    input  logic [SRAM_DW-1:0]  sram_dout
);

    if (RSPQ_DEPTH < 2 || (RSPQ_DEPTH & (RSPQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RSPQ_DEPTH must be a power of two and at least 2");
    end

    logic               r_live;
    logic               r_men;
    logic               r_wen;
    logic               r_ren;
    logic [SRAM_AW-1:0] r_addr;
    logic [SRAM_DW-1:0] r_bm;
    logic [SRAM_DW-1:0] r_din;
    logic               w_accept;
    logic               w_pop;

    assign w_accept  = req_valid && req_ready;
    assign sram_men  = r_men;
    assign sram_wen  = r_wen;
    assign sram_ren  = r_ren;
    assign sram_addr = r_addr;
    assign sram_bm   = r_bm;
    assign sram_din  = r_din;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_men  <= 1'b0;
            r_wen  <= 1'b0;
            r_ren  <= 1'b0;
            r_addr <= '0;
            r_bm   <= '0;
            r_din  <= '0;
        end else begin
            r_live <= 1'b1;
            r_men  <= w_accept;
            r_wen  <= w_accept && req_we;
            r_ren  <= w_accept && !req_we;
            if (w_accept) begin
                r_addr <= req_addr;
                r_bm   <= be_to_bm(req_be);
                r_din  <= req_wdata;
            end
        end
    end

`ifdef SRAM_REQ_CTRL_RSPQ_EN
    localparam int CW = $clog2(RSPQ_DEPTH);

    logic               r_cap_vld;
    logic               w_empty;
    logic               w_full;
    logic [CW:0]        w_count;
    logic [CW+1:0]      w_occ;
    logic [SRAM_DW-1:0] w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cap_vld <= 1'b0;
        else        r_cap_vld <= r_ren;
    end

    sram_rsp_fifo #(
        .DEPTH (RSPQ_DEPTH),
        .WIDTH (SRAM_DW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_cap_vld),
        .i_wdata (sram_dout),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Reads still at the pins or being sampled have a FIFO slot reserved.
    assign w_occ     = {1'b0, w_count} + (CW+2)'(r_ren) + (CW+2)'(r_cap_vld) - (CW+2)'(w_pop);
    assign rsp_valid = !w_empty;
    assign rsp_rdata = w_empty ? '0 : w_head;
    assign w_pop     = rsp_valid && rsp_ready;
    assign req_ready = r_live && !(w_full && !w_pop) && (w_occ < (CW+2)'(RSPQ_DEPTH));
`else
    state_t             r_state;
    state_t             w_next;
    logic [SRAM_DW-1:0] r_rdata;

    assign rsp_valid = (r_state == ST_RSP);
    assign rsp_rdata = r_rdata;
    assign w_pop     = rsp_valid && rsp_ready;
    assign req_ready = r_live && ((r_state == ST_IDLE) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CAP) r_rdata <= sram_dout;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !req_we) w_next = ST_ACC;
            ST_ACC:  w_next = ST_CAP;
            ST_CAP:  w_next = ST_RSP;
            ST_RSP:  if (w_pop) w_next = (w_accept && !req_we) ? ST_ACC : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end
`endif

endmodule
